router_reg: RTL and testbench
=============================

ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 Parameter DATA_W, default 8, byte width of header, payload and parity.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 pkt_valid  input  1  source byte qualifier; falls on the parity byte.
REQ-005 data_in  input  DATA_W  source byte; header bits [1:0] = destination address.
REQ-006 fifo_full  input  1  selected destination FIFO full.
REQ-007 detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg  input  1 each  one-hot controller state decodes.
REQ-008 dout  output  DATA_W  byte presented to the destination FIFO.
REQ-009 parity_done  output  1  parity byte captured for the current packet.
REQ-010 low_pkt_valid  output  1  pkt_valid seen low while loading data.
REQ-011 err  output  1  parity mismatch flag for the last packet.

Function
REQ-012 The block SHALL capture data_in into header_byte when detect_add & pkt_valid & data_in[1:0] != 3; address 3 SHALL leave header_byte unchanged.
REQ-013 When lfd_state = 1, the block SHALL load dout with header_byte, one cycle latency.
REQ-014 When ld_state = 1 and fifo_full = 0, the block SHALL load dout with data_in.
REQ-015 When ld_state = 1 and fifo_full = 1, the block SHALL load holding register full_byte with data_in and hold dout.
REQ-016 When laf_state = 1, the block SHALL load dout with full_byte.
REQ-017 In all other cycles, dout, header_byte and full_byte SHALL hold.
REQ-018 internal_parity SHALL clear on detect_add, XOR header_byte on lfd_state, XOR data_in when ld_state & pkt_valid & !full_state, else hold.
REQ-019 When ld_state & !fifo_full & !pkt_valid, the block SHALL latch data_in into packet_parity and set parity_done.
REQ-020 When laf_state & low_pkt_valid & !parity_done, the block SHALL latch full_byte into packet_parity and set parity_done.
REQ-021 parity_done SHALL clear on detect_add and otherwise hold.
REQ-022 low_pkt_valid SHALL set when ld_state & !pkt_valid, clear when rst_int_reg = 1, else hold; clear wins over set.
REQ-023 When rst_int_reg = 1, the block SHALL set err = (packet_parity != internal_parity); err SHALL clear on detect_add, else hold.
REQ-024 Only one state decode is asserted at a time; the block SHALL give no priority among them beyond REQ-022.
REQ-025 All arithmetic is bitwise XOR at DATA_W bits; no carry, no wrap.

Reset
REQ-026 When resetn = 0 at a rising edge, dout, header_byte, full_byte, internal_parity, packet_parity, parity_done, low_pkt_valid and err SHALL become 0, overriding every other input.
REQ-027 A reset in mid-packet SHALL discard all packet state; the next packet SHALL start clean from detect_add.

Structure
REQ-028 Package router_pkg SHALL hold DATA_W, ADDR_W = 2 and ADDR_INVALID = 2'd3, shared with the FSM, synchroniser and FIFO.
REQ-029 The internal_parity/packet_parity/err logic SHALL be a sub-module named router_parity_chk; datapath registers stay in router_reg.
REQ-030 All outputs SHALL be registered; there is no combinational path from any input to any output.

Verification
REQ-031 Header 8'h0D (addr 1), payload 8'h11, 8'h22, 8'h33, parity 8'h0D, no full -> dout sequence 0D, 11, 22, 33, 0D; parity_done = 1; err = 0 after rst_int_reg.
REQ-032 Same packet with parity 8'h0C -> err = 1 after rst_int_reg; err = 0 after the next detect_add.
REQ-033 fifo_full = 1 during ld_state on byte 8'h22 -> full_byte = 22; dout holds 11; dout = 22 in laf_state; err = 0.
REQ-034 fifo_full = 1 on the parity byte 8'h0D -> low_pkt_valid = 1; parity_done = 1 and packet_parity = 0D in laf_state; err = 0.
REQ-035 Header 8'h0F (addr 3) with detect_add -> header_byte unchanged; subsequent lfd_state outputs the previous header.
REQ-036 resetn = 0 after byte 8'h22 -> all outputs 0 next cycle; the following valid packet checks with err = 0.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: widths and address constants shared by the router blocks
package router_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;
   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;
endpackage

// File: rtl/router_parity_chk.sv
// router_parity_chk: running packet parity, received parity byte and mismatch flag
import router_pkg::*;
module router_parity_chk #(
   parameter int DATA_W = router_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              full_state,
   input  logic              rst_int_reg,
   input  logic              pkt_valid,
   input  logic              par_from_data,
   input  logic              par_from_full,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] header_byte,
   input  logic [DATA_W-1:0] full_byte,
   output logic              err
);
   logic [DATA_W-1:0] internal_parity, packet_parity;
   // Accumulate XOR of header and every payload byte accepted from the source
   always_ff @(posedge clock)
      if (!resetn) internal_parity <= '0;
      else if (detect_add) internal_parity <= '0;
      else if (lfd_state) internal_parity <= internal_parity ^ header_byte;
      else if (ld_state && pkt_valid && !full_state) internal_parity <= internal_parity ^ data_in;
   // Capture the parity byte, either straight from the source or from the holding register
   always_ff @(posedge clock)
      if (!resetn) packet_parity <= '0;
      else if (par_from_data) packet_parity <= data_in;
      else if (par_from_full) packet_parity <= full_byte;
   // Compare at end of packet; cleared when the next packet starts
   always_ff @(posedge clock)
      if (!resetn) err <= 1'b0;
      else if (detect_add) err <= 1'b0;
      else if (rst_int_reg) err <= packet_parity != internal_parity;
endmodule

// File: rtl/router_reg.sv
// router_reg: router datapath registers (header, holding byte, output byte, parity status)
import router_pkg::*;
module router_reg #(
   parameter int DATA_W = router_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              full_state,
   input  logic              laf_state,
   input  logic              rst_int_reg,
   output logic [DATA_W-1:0] dout,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err
);
   logic [DATA_W-1:0] header_byte, full_byte;
   logic par_from_data, par_from_full;
   assign par_from_data = ld_state & ~fifo_full & ~pkt_valid;
   assign par_from_full = laf_state & low_pkt_valid & ~parity_done;
   // Latch the header unless it addresses the unused port
   always_ff @(posedge clock)
      if (!resetn) header_byte <= '0;
      else if (detect_add && pkt_valid && data_in[ADDR_W-1:0] != ADDR_INVALID) header_byte <= data_in;
   // Output byte: header, live data, or the byte parked while the FIFO was full
   always_ff @(posedge clock)
      if (!resetn) dout <= '0;
      else if (lfd_state) dout <= header_byte;
      else if (ld_state && !fifo_full) dout <= data_in;
      else if (laf_state) dout <= full_byte;
   // Park the byte that arrived while the destination FIFO was full
   always_ff @(posedge clock)
      if (!resetn) full_byte <= '0;
      else if (ld_state && fifo_full) full_byte <= data_in;
   // Parity byte has been captured for this packet
   always_ff @(posedge clock)
      if (!resetn) parity_done <= 1'b0;
      else if (detect_add) parity_done <= 1'b0;
      else if (par_from_data || par_from_full) parity_done <= 1'b1;
   // Source has dropped pkt_valid during load; end-of-packet clear wins
   always_ff @(posedge clock)
      if (!resetn) low_pkt_valid <= 1'b0;
      else if (rst_int_reg) low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid) low_pkt_valid <= 1'b1;
   router_parity_chk #(.DATA_W(DATA_W)) u_chk (
      .clock(clock),
      .resetn(resetn),
      .detect_add(detect_add),
      .lfd_state(lfd_state),
      .ld_state(ld_state),
      .full_state(full_state),
      .rst_int_reg(rst_int_reg),
      .pkt_valid(pkt_valid),
      .par_from_data(par_from_data),
      .par_from_full(par_from_full),
      .data_in(data_in),
      .header_byte(header_byte),
      .full_byte(full_byte),
      .err(err)
   );
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: packet-level checks of router_reg with directed and random packets
module tb_router_reg;
   logic clock = 1'b0;
   logic resetn, pkt_valid, fifo_full;
   logic detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
   logic [7:0] data_in, dout;
   logic parity_done, low_pkt_valid, err;
   int vectors = 0;
   int miscompares = 0;
   logic [7:0] cur_hdr = 8'h00;
   logic [7:0] pay [0:15];

   router_reg #(.DATA_W(8)) dut (
      .clock(clock),
      .resetn(resetn),
      .pkt_valid(pkt_valid),
      .data_in(data_in),
      .fifo_full(fifo_full),
      .detect_add(detect_add),
      .lfd_state(lfd_state),
      .ld_state(ld_state),
      .full_state(full_state),
      .laf_state(laf_state),
      .rst_int_reg(rst_int_reg),
      .dout(dout),
      .parity_done(parity_done),
      .low_pkt_valid(low_pkt_valid),
      .err(err)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic clr;
      detect_add = 0; lfd_state = 0; ld_state = 0; full_state = 0; laf_state = 0; rst_int_reg = 0;
      fifo_full = 0; pkt_valid = 0; data_in = 8'($urandom);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one packet the way the controller would; stall = byte index seeing fifo_full (n = parity byte, -1 none)
   task automatic send(input logic [7:0] hdr, input int n, input logic [7:0] par, input int stall);
      logic [7:0] x, last, b;
      clr; detect_add = 1; pkt_valid = 1; data_in = hdr; tick;
      if (hdr[1:0] != 2'd3) cur_hdr = hdr;
      chk("pdone_clr", {7'd0, parity_done}, 8'd0);
      chk("err_clr", {7'd0, err}, 8'd0);
      clr; lfd_state = 1; pkt_valid = 1; tick;
      chk("lfd_dout", dout, cur_hdr);
      last = cur_hdr;
      x = cur_hdr;
      for (int i = 0; i <= n; i++) begin
         b = (i < n) ? pay[i] : par;
         clr; ld_state = 1; pkt_valid = (i < n); data_in = b; fifo_full = (i == stall); tick;
         if (i < n) x ^= b;
         chk("ld_dout", dout, (i == stall) ? last : b);
         if (i == n) chk("pdone_ld", {7'd0, parity_done}, {7'd0, stall != n});
         if (i == stall) begin
            clr; full_state = 1; fifo_full = 1; pkt_valid = (i < n); tick;
            chk("full_hold", dout, last);
            clr; laf_state = 1; pkt_valid = (i < n); tick;
            chk("laf_dout", dout, b);
         end
         last = b;
      end
      chk("pdone_end", {7'd0, parity_done}, 8'd1);
      chk("lpv_set", {7'd0, low_pkt_valid}, 8'd1);
      clr; rst_int_reg = 1; tick;
      chk("err_end", {7'd0, err}, {7'd0, x != par});
      chk("lpv_clr", {7'd0, low_pkt_valid}, 8'd0);
      chk("dout_hold", dout, last);
      clr; tick;
   endtask

   initial begin
      logic [7:0] h, p, xr;
      int n, st;
      clr; resetn = 0; tick; tick;
      chk("rst_dout", dout, 8'h00);
      chk("rst_pdone", {7'd0, parity_done}, 8'd0);
      chk("rst_lpv", {7'd0, low_pkt_valid}, 8'd0);
      chk("rst_err", {7'd0, err}, 8'd0);
      resetn = 1;
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      send(8'h0D, 3, 8'h0D, -1);
      send(8'h0D, 3, 8'h0C, -1);
      send(8'h0D, 3, 8'h0D, 1);
      send(8'h0D, 3, 8'h0D, 3);
      send(8'h0F, 3, 8'h0D, -1);
      clr; detect_add = 1; pkt_valid = 1; data_in = 8'h0D; tick;
      clr; lfd_state = 1; pkt_valid = 1; tick;
      clr; ld_state = 1; pkt_valid = 1; data_in = 8'h11; tick;
      clr; ld_state = 1; pkt_valid = 1; data_in = 8'h22; resetn = 0; tick;
      resetn = 1;
      cur_hdr = 8'h00;
      chk("mid_rst_dout", dout, 8'h00);
      chk("mid_rst_pdone", {7'd0, parity_done}, 8'd0);
      chk("mid_rst_lpv", {7'd0, low_pkt_valid}, 8'd0);
      chk("mid_rst_err", {7'd0, err}, 8'd0);
      clr; tick;
      send(8'h0F, 3, 8'h00, -1);
      send(8'h0D, 3, 8'h0D, -1);
      for (int k = 0; k < 40; k++) begin
         h = 8'($urandom);
         n = $urandom_range(1, 8);
         xr = (h[1:0] != 2'd3) ? h : cur_hdr;
         for (int j = 0; j < n; j++) begin
            pay[j] = 8'($urandom);
            xr ^= pay[j];
         end
         p = ($urandom_range(0, 1) == 1) ? xr : 8'($urandom);
         st = $urandom_range(0, 2) == 0 ? -1 : $urandom_range(0, n);
         send(h, n, p, st);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
